vga_ctrl: RTL and testbench

VGA 640×480@60 Hz timing generator and pixel output stage. It sits directly upstream and downstream of the framebuffer. It drives `h_addr`/`v_addr` into the framebuffer read port and takes the 12-bit RGB444 word back on `vga_data`. It then emits blanked RGB plus `hsync`/`vsync`, aligned to the framebuffer read latency.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_ctrl.sv | 103 ++++++++++
 tb/tb_vga_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types and default 640x480@60 timing.
// VGA_FB_SYNC_READ_EN selects the registered-read framebuffer latency.
package vga_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

`ifdef VGA_FB_SYNC_READ_EN
   localparam int unsigned VGA_FB_LAT = 1;
`else
   localparam int unsigned VGA_FB_LAT = 0;
`endif

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA timing axis: counter over active/front porch/sync/back porch,
// with the active-region flag, active-low sync and end-of-axis wrap strobe.
module vga_axis_counter #(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   output logic [9:0] cnt,
   output logic       active,
   output logic       sync_n,
   output logic       wrap
);

   localparam logic [9:0] ACT_END  = 10'(ACTIVE);
   localparam logic [9:0] SYNC_BEG = 10'(ACTIVE + FP);
   localparam logic [9:0] SYNC_END = 10'(ACTIVE + FP + SYNC);
   localparam logic [9:0] LAST     = 10'(ACTIVE + FP + SYNC + BP - 1);

   logic [9:0] cnt_q, cnt_d;

   always_comb begin
      wrap  = inc && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = wrap ? '0 : cnt_q + 10'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt    = cnt_q;
      active = (cnt_q < ACT_END);
      sync_n = !((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END));
   end

endmodule

// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator and blanked pixel output stage.
// Define VGA_FB_SYNC_READ_EN for a framebuffer with a 1-clock registered read.
module vga_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   logic [9:0] h_cnt, v_cnt;
   logic       h_act, v_act, h_sync_n, v_sync_n, h_wrap, v_wrap_unused;
   logic       vis;
   rgb444_t    pix;

   vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (1'b1),
      .cnt    (h_cnt),
      .active (h_act),
      .sync_n (h_sync_n),
      .wrap   (h_wrap)
   );

   vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (h_wrap),
      .cnt    (v_cnt),
      .active (v_act),
      .sync_n (v_sync_n),
      .wrap   (v_wrap_unused)
   );

   // Counters already sit at (0,0) in reset, so the address-stage strobe is gated by reset.
   always_comb begin
      vis         = h_act && v_act;
      h_addr      = h_act ? h_cnt : '0;
      v_addr      = v_act ? v_cnt : '0;
      frame_start = reset && (h_cnt == '0) && (v_cnt == '0);
      pix         = rgb444_t'(vga_data);
   end

`ifdef VGA_FB_SYNC_READ_EN
   logic hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;

   always_comb begin
      hsync_d = h_sync_n;
      vsync_d = v_sync_n;
      valid_d = vis;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      hsync = hsync_q;
      vsync = vsync_q;
      valid = valid_q;
   end
`else
   always_comb begin
      hsync = h_sync_n;
      vsync = v_sync_n;
      valid = vis && reset;
   end
`endif

   always_comb begin
      vga_r = valid ? pix.r : '0;
      vga_g = valid ? pix.g : '0;
      vga_b = valid ? pix.b : '0;
   end

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl: a linear-position frame model feeds expected
// outputs into a queue that a negedge monitor drains against the DUT.
module tb_vga_ctrl;
   import vga_pkg::*;

   localparam int H_TOT  = 800;
   localparam int V_TOT  = 525;
   localparam int FRAME  = H_TOT * V_TOT;
   localparam int H_VIS  = 640;
   localparam int V_VIS  = 480;
   localparam int HS_BEG = 656;
   localparam int HS_END = 752;
   localparam int VS_BEG = 490;
   localparam int VS_END = 492;
   localparam int LAT    = int'(VGA_FB_LAT);

   typedef struct {
      int ha;
      int va;
      int hs;
      int vs;
      int vld;
      int rgb;
      int fs;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] vga_data;
   logic [9:0]  h_addr, v_addr;
   logic        hsync, vsync, valid, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic [9:0]  seek_h, seek_v;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   p  = 0;   // linear address-stage position in the frame
   int   po = -1;  // position whose sync/valid/pixel is on the outputs; -1 = cleared

   always #5 clock = ~clock;

   // Framebuffer stand-in: pixel word encodes the address it was read from.
`ifdef VGA_FB_SYNC_READ_EN
   logic [11:0] fb_q;
   always @(posedge clock) fb_q <= {h_addr[3:0], v_addr[3:0], 4'hA};
   assign vga_data = fb_q;
`else
   assign vga_data = {h_addr[3:0], v_addr[3:0], 4'hA};
`endif

   vga_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .vga_data    (vga_data),
      .h_addr      (h_addr),
      .v_addr      (v_addr),
      .hsync       (hsync),
      .vsync       (vsync),
      .valid       (valid),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   function automatic exp_t model(int a, int o, bit in_rst);
      exp_t e;
      int h, v, oh, ov;
      e = '{ha: 0, va: 0, hs: 1, vs: 1, vld: 0, rgb: 0, fs: 0};
      if (in_rst) return e;
      h    = a % H_TOT;
      v    = a / H_TOT;
      e.ha = (h < H_VIS) ? h : 0;
      e.va = (v < V_VIS) ? v : 0;
      e.fs = (a == 0) ? 1 : 0;
      if (o >= 0) begin
         oh    = o % H_TOT;
         ov    = o / H_TOT;
         e.hs  = (oh >= HS_BEG && oh < HS_END) ? 0 : 1;
         e.vs  = (ov >= VS_BEG && ov < VS_END) ? 0 : 1;
         e.vld = (oh < H_VIS && ov < V_VIS) ? 1 : 0;
         e.rgb = (e.vld != 0) ? (((oh % 16) << 8) | ((ov % 16) << 4) | 10) : 0;
      end
      return e;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t model_pos=%0d: got %0h expected %0h", name, $time, p, act, exp);
      end
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      if (reset == 1'b0) begin
         p  = 0;
         po = -1;
      end else begin
         po = p;
         p  = (p + 1) % FRAME;
      end
   endtask

   task automatic push();
      exp_q.push_back(model(p, (LAT != 0) ? po : p, reset == 1'b0));
   endtask

   task automatic run(int n);
      repeat (n) begin
         advance();
         push();
      end
   endtask

   // Jump the counters to (h,v) for the remainder of the current cycle.
   task automatic seek(int h, int v);
      @(negedge clock);
      #1;
      seek_h = 10'(h);
      seek_v = 10'(v);
      force dut.u_h_cnt.cnt_q = seek_h;
      force dut.u_v_cnt.cnt_q = seek_v;
      #1;
      release dut.u_h_cnt.cnt_q;
      release dut.u_v_cnt.cnt_q;
      p = v * H_TOT + h;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("h_addr", int'(h_addr), e.ha);
            chk("v_addr", int'(v_addr), e.va);
            chk("hsync", int'(hsync), e.hs);
            chk("vsync", int'(vsync), e.vs);
            chk("valid", int'(valid), e.vld);
            chk("rgb", int'({vga_r, vga_g, vga_b}), e.rgb);
            chk("frame_start", int'(frame_start), e.fs);
         end
      end
   end

   initial begin
      seek_h = '0;
      seek_v = '0;
      run(5);
      advance();
      reset = 1'b1;
      push();
      run(2 * H_TOT + 5);

      seek(790, 478);
      run(2 * H_TOT + 100);
      seek(780, 489);
      run(3 * H_TOT + 100);
      seek(795, 524);
      run(20);

      repeat (8) begin
         seek(int'($urandom_range(0, H_TOT - 1)), int'($urandom_range(0, V_TOT - 1)));
         run(int'($urandom_range(20, 400)));
      end

      // Mid-frame reset pulse at (300,200), one clock long.
      seek(295, 200);
      run(4);
      advance();
      reset = 1'b0;
      p     = 0;
      po    = -1;
      push();
      advance();
      reset = 1'b1;
      push();
      run(H_TOT + 100);

      @(negedge clock);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
